// File: rtl/uart_avalon_bridge_pkg.sv
// Shared constants and FSM state type for the UART-to-Avalon debug bridge.
// Frame layout: op, addr[4] LSB first, then wdata[4] LSB first for writes only.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WR = 8'h01;
    localparam logic [7:0] OP_RD = 8'h02;
    localparam logic [7:0] ACK   = 8'hA5;
    localparam logic [7:0] NAK   = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    // States in which a frame is only partly received, so the inter-byte timeout applies.
    function automatic logic is_frame_state(state_t s);
        return (s == ST_ADDR) || (s == ST_WDATA);
    endfunction

endpackage

// File: rtl/uart_avalon_bridge_if.sv
// Byte-stream (UART rx/tx) and Avalon-MM initiator signals of the debug bridge.
// The master modport is the bridge side; the slave modport is the environment side.
interface uart_avalon_bridge_if #(
    parameter int ADDR_WIDTH = 32
);

    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic                  avm_read;
    logic                  avm_write;
    logic [ADDR_WIDTH-1:0] avm_address;
    logic [31:0]           avm_writedata;
    logic [31:0]           avm_readdata;
    logic                  avm_readdatavalid;
    logic                  avm_waitrequest;
    logic                  err_pulse;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest,
        output tx_valid, tx_data,
        output avm_read, avm_write, avm_address, avm_writedata,
        output err_pulse
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        output avm_readdata, avm_readdatavalid, avm_waitrequest,
        input  tx_valid, tx_data,
        input  avm_read, avm_write, avm_address, avm_writedata,
        input  err_pulse
    );

endinterface

// File: rtl/uart_avalon_bridge_txser.sv
// Response serializer: takes 1-4 bytes in one load and presents them LSB first on a
// valid/ready byte stream; done marks acceptance of the final byte.
module uart_bridge_txser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_count,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        done
);

    logic [31:0] shift_q;
    logic [2:0]  left_q;

    assign tx_valid = (left_q != 3'd0);
    assign tx_data  = shift_q[7:0];
    assign done     = tx_valid && tx_ready && (left_q == 3'd1);

    // The shift register only moves on acceptance, so tx_data holds steady under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= 32'd0;
            left_q  <= 3'd0;
        end else if (load && !tx_valid) begin
            shift_q <= load_data;
            left_q  <= load_count;
        end else if (tx_valid && tx_ready) begin
            shift_q <= {8'h00, shift_q[31:8]};
            left_q  <= left_q - 3'd1;
        end
    end

endmodule

// File: rtl/uart_avalon_bridge.sv
// UART-to-Avalon-MM initiator: parses op/addr/wdata frames from the rx byte stream,
// performs one bus access per frame and streams an ack or read data back.
module uart_avalon_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 100000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    uart_avalon_bridge_if.master bus
);

    localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, tmo_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic        is_write_q, err_q, avm_read_q, avm_write_q;
    logic        last_byte, timeout, bad_op, dropped;
    logic        tx_load, tx_done;
    logic [31:0] tx_load_data;
    logic [2:0]  tx_load_count;

    assign last_byte = bus.rx_valid && (byte_cnt_q == 2'd3);
    assign timeout   = (TIMEOUT != 0) && is_frame_state(state_q) && !bus.rx_valid
                       && (tmo_cnt_q == TMO_LAST);
    assign bad_op    = (state_q == ST_IDLE) && bus.rx_valid
                       && (bus.rx_data != OP_WR) && (bus.rx_data != OP_RD);
    assign dropped   = bus.rx_valid
                       && (state_q inside {ST_BUS_WR, ST_BUS_RD, ST_RD_WAIT, ST_RESP});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.rx_valid) state_d = bad_op ? ST_RESP : ST_ADDR;
            ST_ADDR:    if (last_byte)    state_d = is_write_q ? ST_WDATA : ST_BUS_RD;
                        else if (timeout) state_d = ST_IDLE;
            ST_WDATA:   if (last_byte)    state_d = ST_BUS_WR;
                        else if (timeout) state_d = ST_IDLE;
            ST_BUS_WR:  if (!bus.avm_waitrequest)  state_d = ST_RESP;
            ST_BUS_RD:  if (!bus.avm_waitrequest)  state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (bus.avm_readdatavalid) state_d = ST_RESP;
            ST_RESP:    if (tx_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // The serializer is loaded on the same edge that enters RESP.
    always_comb begin
        tx_load       = 1'b0;
        tx_load_data  = 32'd0;
        tx_load_count = 3'd0;
        if (bad_op) begin
            tx_load       = 1'b1;
            tx_load_data  = {24'd0, NAK};
            tx_load_count = 3'd1;
        end else if (state_q == ST_BUS_WR && !bus.avm_waitrequest) begin
            tx_load       = 1'b1;
            tx_load_data  = {24'd0, ACK};
            tx_load_count = 3'd1;
        end else if (state_q == ST_RD_WAIT && bus.avm_readdatavalid) begin
            tx_load       = 1'b1;
            tx_load_data  = bus.avm_readdata;
            tx_load_count = 3'd4;
        end
    end

    // Requests come from flops fed by the next state, so no rx-to-avm combinational path exists.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
        end else begin
            avm_read_q  <= (state_d == ST_BUS_RD);
            avm_write_q <= (state_d == ST_BUS_WR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            tmo_cnt_q  <= 32'd0;
            byte_cnt_q <= 2'd0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= bad_op || timeout || dropped;
            if (!is_frame_state(state_q) || bus.rx_valid) tmo_cnt_q <= 32'd0;
            else                                          tmo_cnt_q <= tmo_cnt_q + 32'd1;
            if (state_q == ST_IDLE) begin
                byte_cnt_q <= 2'd0;
                if (bus.rx_valid) is_write_q <= (bus.rx_data == OP_WR);
            end else if (is_frame_state(state_q) && bus.rx_valid) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (state_q == ST_ADDR) addr_q  <= {bus.rx_data, addr_q[31:8]};
                else                    wdata_q <= {bus.rx_data, wdata_q[31:8]};
            end
        end
    end

    uart_bridge_txser u_txser (
        .clk        (clk),
        .rst        (rst),
        .load       (tx_load),
        .load_data  (tx_load_data),
        .load_count (tx_load_count),
        .tx_ready   (bus.tx_ready),
        .tx_valid   (bus.tx_valid),
        .tx_data    (bus.tx_data),
        .done       (tx_done)
    );

    assign bus.avm_read      = avm_read_q;
    assign bus.avm_write     = avm_write_q;
    assign bus.avm_address   = ADDR_WIDTH'(addr_q);
    assign bus.avm_writedata = wdata_q;
    assign bus.err_pulse     = err_q;

endmodule

// File: tb/tb_uart_avalon_bridge.sv
// Self-checking bench for uart_avalon_bridge: directed scenarios plus random frames,
// scored against a frame-level model of expected bus accesses, response bytes and errors.
module tb_uart_avalon_bridge;

    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_avalon_bridge_if #(.ADDR_WIDTH(32)) bus ();

    uart_avalon_bridge #(.TIMEOUT(TMO), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int          stall_cfg = 0;
    int          rd_lat = 0;
    logic [31:0] rd_value = 32'd0;
    int          ready_mode = 0;

    int stall_left = 0;
    int rdv_cnt = 0;
    bit in_req = 1'b0;
    int rd_high_total = 0;
    int both_viol = 0;
    int stab_viol = 0;
    int err_seen = 0;
    int exp_err = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    logic [63:0] act_wr_q[$];
    logic [63:0] exp_wr_q[$];
    logic [31:0] act_rd_q[$];
    logic [31:0] exp_rd_q[$];
    logic [7:0]  act_tx_q[$];
    logic [7:0]  exp_tx_q[$];

    // Avalon slave: stall_cfg waitrequest cycles per request, read data rd_lat cycles after acceptance.
    always @(negedge clk) begin
        bus.avm_readdatavalid = 1'b0;
        if (rdv_cnt > 0) begin
            rdv_cnt--;
            if (rdv_cnt == 0) bus.avm_readdatavalid = 1'b1;
        end
        bus.avm_readdata = bus.avm_readdatavalid ? rd_value : $urandom();
        if (bus.avm_read || bus.avm_write) begin
            if (!in_req) begin
                in_req     = 1'b1;
                stall_left = stall_cfg;
            end
            if (stall_left > 0) begin
                bus.avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                bus.avm_waitrequest = 1'b0;
                in_req = 1'b0;
                if (bus.avm_write) begin
                    act_wr_q.push_back({bus.avm_address, bus.avm_writedata});
                end else begin
                    act_rd_q.push_back(bus.avm_address);
                    rdv_cnt = rd_lat + 1;
                end
            end
        end else begin
            bus.avm_waitrequest = 1'b0;
            in_req = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.avm_read && bus.avm_write) both_viol++;
        if (bus.avm_read) rd_high_total++;
        if (bus.err_pulse) err_seen++;
        if (rst && prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stab_viol++;
        if (bus.tx_valid && bus.tx_ready) act_tx_q.push_back(bus.tx_data);
        prev_stall = rst && bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = 1'b0;
        endcase
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: run did not complete, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Frame-level model: what the host should observe for one command frame.
    task automatic model_frame(input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata);
        if (op == 8'h01) begin
            exp_wr_q.push_back({addr, wdata});
            exp_tx_q.push_back(8'hA5);
        end else if (op == 8'h02) begin
            exp_rd_q.push_back(addr);
            for (int i = 0; i < 4; i++) exp_tx_q.push_back(rdata[8*i +: 8]);
        end else begin
            exp_tx_q.push_back(8'hEE);
            exp_err++;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int max_gap);
        rd_value = rdata;
        send_byte(op, int'($urandom_range(0, max_gap)));
        if (op == 8'h01 || op == 8'h02)
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], int'($urandom_range(0, max_gap)));
        if (op == 8'h01)
            for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8], int'($urandom_range(0, max_gap)));
        model_frame(op, addr, wdata, rdata);
    endtask

    task automatic wait_and_check(input string tag);
        int guard = 0;
        logic [7:0]  a8, e8;
        logic [63:0] a64, e64;
        logic [31:0] a32, e32;
        while (act_tx_q.size() < exp_tx_q.size() && guard < 2000) begin
            tick();
            guard++;
        end
        tick();
        check_output({tag, "_tx_count"}, 64'(act_tx_q.size()), 64'(exp_tx_q.size()));
        check_output({tag, "_wr_count"}, 64'(act_wr_q.size()), 64'(exp_wr_q.size()));
        check_output({tag, "_rd_count"}, 64'(act_rd_q.size()), 64'(exp_rd_q.size()));
        check_output({tag, "_err_count"}, 64'(err_seen), 64'(exp_err));
        while (act_tx_q.size() > 0 && exp_tx_q.size() > 0) begin
            a8 = act_tx_q.pop_front();
            e8 = exp_tx_q.pop_front();
            check_output({tag, "_tx_byte"}, 64'(a8), 64'(e8));
        end
        while (act_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            a64 = act_wr_q.pop_front();
            e64 = exp_wr_q.pop_front();
            check_output({tag, "_wr_addr_data"}, a64, e64);
        end
        while (act_rd_q.size() > 0 && exp_rd_q.size() > 0) begin
            a32 = act_rd_q.pop_front();
            e32 = exp_rd_q.pop_front();
            check_output({tag, "_rd_addr"}, 64'(a32), 64'(e32));
        end
        act_tx_q.delete(); exp_tx_q.delete();
        act_wr_q.delete(); exp_wr_q.delete();
        act_rd_q.delete(); exp_rd_q.delete();
    endtask

    initial begin
        int          rh0;
        int          guard;
        int          r;
        logic [7:0]  op;
        logic [31:0] rdata;

        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (3) tick();
        check_output("reset_ctrl", {60'd0, bus.avm_read, bus.avm_write, bus.tx_valid, bus.err_pulse}, 64'd0);
        check_output("reset_addr", 64'(bus.avm_address), 64'd0);
        check_output("reset_wdata", 64'(bus.avm_writedata), 64'd0);
        check_output("reset_txdata", 64'(bus.tx_data), 64'd0);
        rst = 1'b1;
        repeat (2) tick();

        $display("[TB] directed write and stalled read");
        apply_stimulus(8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 0);
        wait_and_check("wr_directed");
        rh0       = rd_high_total;
        stall_cfg = 3;
        apply_stimulus(8'h02, 32'h0000_0004, 32'd0, 32'h0000_0041, 0);
        wait_and_check("rd_stall");
        check_output("rd_hold_cycles", 64'(rd_high_total - rh0), 64'd4);

        $display("[TB] bad opcode then recovery");
        stall_cfg = 0;
        apply_stimulus(8'h7F, 32'd0, 32'd0, 32'd0, 0);
        wait_and_check("bad_op");
        apply_stimulus(8'h01, $urandom(), $urandom(), 32'd0, 2);
        wait_and_check("after_bad_op");

        $display("[TB] inter-byte timeout");
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        repeat (60) tick();
        exp_err++;
        wait_and_check("timeout");
        apply_stimulus(8'h01, 32'h0000_0010, $urandom(), 32'd0, 1);
        wait_and_check("after_timeout");

        $display("[TB] response backpressure with dropped byte");
        ready_mode = 2;
        stall_cfg  = 1;
        rd_lat     = 2;
        rdata      = $urandom();
        apply_stimulus(8'h02, $urandom(), 32'd0, rdata, 1);
        guard = 0;
        while (bus.tx_valid !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        check_output("stall_valid", 64'(bus.tx_valid), 64'd1);
        send_byte(8'h55, 0);
        exp_err++;
        repeat (20) tick();
        check_output("stall_valid_hold", 64'(bus.tx_valid), 64'd1);
        check_output("stall_data", 64'(bus.tx_data), 64'(rdata[7:0]));
        ready_mode = 0;
        wait_and_check("backpressure_drop");

        $display("[TB] random frames");
        ready_mode = 1;
        for (int n = 0; n < 24; n++) begin
            stall_cfg = int'($urandom_range(0, 3));
            rd_lat    = int'($urandom_range(0, 3));
            r         = int'($urandom_range(0, 9));
            op        = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom_range(3, 255));
            apply_stimulus(op, $urandom(), $urandom(), $urandom(), 3);
            wait_and_check("rand");
        end

        $display("[TB] async reset with write pending");
        ready_mode = 0;
        stall_cfg  = 1000;
        send_byte(8'h01, 0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom()), 0);
        guard = 0;
        while (bus.avm_write !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        check_output("wr_pending", 64'(bus.avm_write), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("reset_kills_write", 64'(bus.avm_write), 64'd0);
        check_output("reset_kills_read", 64'(bus.avm_read), 64'd0);
        check_output("reset_tx_valid", 64'(bus.tx_valid), 64'd0);
        tick();
        tick();
        rst       = 1'b1;
        stall_cfg = 0;
        tick();
        apply_stimulus(8'h02, $urandom(), 32'd0, $urandom(), 1);
        wait_and_check("after_reset");

        check_output("no_rd_wr_overlap", 64'(both_viol), 64'd0);
        check_output("tx_stable_when_stalled", 64'(stab_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
